// File: rtl/decode_stage_if.sv
// Bundle of D-stage inputs, forwarding sources, write-back ports, pipeline
// control and the registered E-stage outputs of the Y86-64 decode stage.
interface decode_stage_if #(
    parameter int DATA_W = 64
);
    // D pipeline register fields
    logic [1:0]        D_stat;
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [3:0]        D_rA;
    logic [3:0]        D_rB;
    logic [DATA_W-1:0] D_valC;
    logic [DATA_W-1:0] D_valP;

    // Forwarding sources from younger stages
    logic [3:0]        e_dstE;
    logic [DATA_W-1:0] e_valE;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] m_valM;

    // Write-back (also the register-file write ports)
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;

    // Pipeline control. Bubble overrides stall; neither gates register writes.
    logic              E_stall;
    logic              E_bubble;

    // Outputs
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [1:0]        E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valC;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [3:0]        E_dstE;
    logic [3:0]        E_dstM;
    logic [3:0]        E_srcA;
    logic [3:0]        E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        output W_dstE, W_dstM, W_valE, W_valM,
        output E_stall, E_bubble,
        input  d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        input  W_dstE, W_dstM, W_valE, W_valM,
        input  E_stall, E_bubble,
        output d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode/write-back stage: register file, register-ID generation,
// valA/valB forwarding and the E pipeline register with stall/bubble.
module decode_stage #(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF,
    parameter logic [3:0] RSP    = 4'h4
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dif
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [1:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [3:0]        dst_e;
        logic [3:0]        dst_m;
        logic [3:0]        src_a;
        logic [3:0]        src_b;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  2'b00,
        icode: I_NOP,
        ifun:  4'h0,
        val_c: '0,
        val_a: '0,
        val_b: '0,
        dst_e: RNONE,
        dst_m: RNONE,
        src_a: RNONE,
        src_b: RNONE
    };

    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Entry 15 exists only so a 4-bit ID indexes the array cleanly; it stays 0.
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    e_reg_t e_q;
    e_reg_t e_d;

    // ---------------------------------------------------------------
    // Register-ID generation
    // ---------------------------------------------------------------
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;

        case (dif.D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = dif.D_rA;
            I_RET, I_POPQ:                      src_a = RSP;
            default:                            src_a = RNONE;
        endcase

        case (dif.D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = dif.D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP;
            default:                            src_b = RNONE;
        endcase

        // Conditional moves are squashed in execute, so rrmovq always names rB.
        case (dif.D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = dif.D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP;
            default:                            dst_e = RNONE;
        endcase

        case (dif.D_icode)
            I_MRMOVQ, I_POPQ:                   dst_m = dif.D_rA;
            default:                            dst_m = RNONE;
        endcase
    end

    assign dif.d_srcA = src_a;
    assign dif.d_srcB = src_b;

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    assign rd_a = (src_a == RNONE) ? '0 : rf_q[src_a];
    assign rd_b = (src_b == RNONE) ? '0 : rf_q[src_b];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (dif.W_dstE != RNONE) begin
            rf_d[dif.W_dstE] = dif.W_valE;
        end
        // Applied second so popq %rsp leaves the popped value in %rsp.
        if (dif.W_dstM != RNONE) begin
            rf_d[dif.W_dstM] = dif.W_valM;
        end
        rf_d[15] = '0;
    end

    // ---------------------------------------------------------------
    // Forwarding: youngest producer first, then the register read
    // ---------------------------------------------------------------
    always_comb begin
        fwd_a = rd_a;
        if (dif.D_icode == I_JXX || dif.D_icode == I_CALL) begin
            fwd_a = dif.D_valP;
        end else if (src_a != RNONE) begin
            if (src_a == dif.e_dstE) begin
                fwd_a = dif.e_valE;
            end else if (src_a == dif.M_dstM) begin
                fwd_a = dif.m_valM;
            end else if (src_a == dif.M_dstE) begin
                fwd_a = dif.M_valE;
            end else if (src_a == dif.W_dstM) begin
                fwd_a = dif.W_valM;
            end else if (src_a == dif.W_dstE) begin
                fwd_a = dif.W_valE;
            end
        end
    end

    always_comb begin
        fwd_b = rd_b;
        if (src_b != RNONE) begin
            if (src_b == dif.e_dstE) begin
                fwd_b = dif.e_valE;
            end else if (src_b == dif.M_dstM) begin
                fwd_b = dif.m_valM;
            end else if (src_b == dif.M_dstE) begin
                fwd_b = dif.M_valE;
            end else if (src_b == dif.W_dstM) begin
                fwd_b = dif.W_valM;
            end else if (src_b == dif.W_dstE) begin
                fwd_b = dif.W_valE;
            end
        end
    end

    // ---------------------------------------------------------------
    // E pipeline register: bubble > stall > load
    // ---------------------------------------------------------------
    always_comb begin
        e_d = e_q;
        if (dif.E_bubble) begin
            e_d = E_BUBBLE;
        end else if (!dif.E_stall) begin
            e_d.stat  = dif.D_stat;
            e_d.icode = dif.D_icode;
            e_d.ifun  = dif.D_ifun;
            e_d.val_c = dif.D_valC;
            e_d.val_a = fwd_a;
            e_d.val_b = fwd_b;
            e_d.dst_e = dst_e;
            e_d.dst_m = dst_m;
            e_d.src_a = src_a;
            e_d.src_b = src_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= E_BUBBLE;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            e_q <= e_d;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign dif.E_stat  = e_q.stat;
    assign dif.E_icode = e_q.icode;
    assign dif.E_ifun  = e_q.ifun;
    assign dif.E_valC  = e_q.val_c;
    assign dif.E_valA  = e_q.val_a;
    assign dif.E_valB  = e_q.val_b;
    assign dif.E_dstE  = e_q.dst_e;
    assign dif.E_dstM  = e_q.dst_m;
    assign dif.E_srcA  = e_q.src_a;
    assign dif.E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps from the test plan followed by a
// randomized run, all checked against a register-file/E-register model.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_stage_if #(.DATA_W(64)) dif ();

  decode_stage #(.DATA_W(64), .RNONE(4'hF), .RSP(4'h4)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] valc, vala, valb;
    logic [3:0]  dste, dstm, srca, srcb;
  } e_model_t;

  logic [63:0] ref_rf [15];
  e_model_t    m_e;
  e_model_t    saved_e;

  function automatic e_model_t bubble_e();
    e_model_t b;
    b.stat = 2'b00; b.icode = 4'h1; b.ifun = 4'h0;
    b.valc = 64'h0; b.vala = 64'h0; b.valb = 64'h0;
    b.dste = 4'hF; b.dstm = 4'hF; b.srca = 4'hF; b.srcb = 4'hF;
    return b;
  endfunction

  function automatic logic [3:0] m_srca(logic [3:0] ic, logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcb(logic [3:0] ic, logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dste(logic [3:0] ic, logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstm(logic [3:0] ic, logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  // Walk the producer list youngest-first; fall back to the model register file.
  function automatic logic [63:0] m_operand(logic [3:0] src);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    ids  = '{dif.e_dstE, dif.M_dstM, dif.M_dstE, dif.W_dstM, dif.W_dstE};
    vals = '{dif.e_valE, dif.m_valM, dif.M_valE, dif.W_valM, dif.W_valE};
    if (src == 4'hF) return 64'h0;
    for (int i = 0; i < 5; i++) begin
      if (ids[i] == src) return vals[i];
    end
    return ref_rf[src];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e_all(input string tag);
    chk({tag, ".E_stat"},  64'(dif.E_stat),  64'(m_e.stat));
    chk({tag, ".E_icode"}, 64'(dif.E_icode), 64'(m_e.icode));
    chk({tag, ".E_ifun"},  64'(dif.E_ifun),  64'(m_e.ifun));
    chk({tag, ".E_valC"},  dif.E_valC,       m_e.valc);
    chk({tag, ".E_valA"},  dif.E_valA,       m_e.vala);
    chk({tag, ".E_valB"},  dif.E_valB,       m_e.valb);
    chk({tag, ".E_dstE"},  64'(dif.E_dstE),  64'(m_e.dste));
    chk({tag, ".E_dstM"},  64'(dif.E_dstM),  64'(m_e.dstm));
    chk({tag, ".E_srcA"},  64'(dif.E_srcA),  64'(m_e.srca));
    chk({tag, ".E_srcB"},  64'(dif.E_srcB),  64'(m_e.srcb));
  endtask

  // One clock: check combinational IDs, advance the model, then compare E.
  task automatic tick(input string tag);
    e_model_t nxt;
    logic [3:0] sa, sb;
    #1;
    sa = m_srca(dif.D_icode, dif.D_rA);
    sb = m_srcb(dif.D_icode, dif.D_rB);
    chk({tag, ".d_srcA"}, 64'(dif.d_srcA), 64'(sa));
    chk({tag, ".d_srcB"}, 64'(dif.d_srcB), 64'(sb));
    nxt = m_e;
    if (rst || dif.E_bubble) begin
      nxt = bubble_e();
    end else if (!dif.E_stall) begin
      nxt.stat  = dif.D_stat;
      nxt.icode = dif.D_icode;
      nxt.ifun  = dif.D_ifun;
      nxt.valc  = dif.D_valC;
      nxt.vala  = (dif.D_icode inside {4'h7, 4'h8}) ? dif.D_valP : m_operand(sa);
      nxt.valb  = m_operand(sb);
      nxt.dste  = m_dste(dif.D_icode, dif.D_rB);
      nxt.dstm  = m_dstm(dif.D_icode, dif.D_rA);
      nxt.srca  = sa;
      nxt.srcb  = sb;
    end
    if (rst) begin
      for (int i = 0; i < 15; i++) ref_rf[i] = 64'h0;
    end else begin
      if (dif.W_dstE != 4'hF) ref_rf[dif.W_dstE] = dif.W_valE;
      if (dif.W_dstM != 4'hF) ref_rf[dif.W_dstM] = dif.W_valM;
    end
    m_e = nxt;
    @(posedge clk);
    #1;
    chk_e_all(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_fwd();
    dif.e_dstE = 4'hF; dif.M_dstE = 4'hF; dif.M_dstM = 4'hF;
    dif.W_dstE = 4'hF; dif.W_dstM = 4'hF;
  endtask

  task automatic rand_data();
    dif.D_stat = 2'($urandom_range(0, 3));
    dif.D_ifun = 4'($urandom_range(0, 15));
    dif.D_valC = {$urandom, $urandom};
    dif.D_valP = {$urandom, $urandom};
    dif.e_valE = {$urandom, $urandom};
    dif.M_valE = {$urandom, $urandom};
    dif.m_valM = {$urandom, $urandom};
    dif.W_valE = {$urandom, $urandom};
    dif.W_valM = {$urandom, $urandom};
  endtask

  task automatic decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    dif.D_icode = ic; dif.D_rA = ra; dif.D_rB = rb;
  endtask

  function automatic logic [3:0] rand_id();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    m_e = bubble_e();
    for (int i = 0; i < 15; i++) ref_rf[i] = 64'h0;
    rst = 1'b1;
    dif.E_stall = 1'b0; dif.E_bubble = 1'b0;
    rand_data();
    decode(4'($urandom_range(0, 11)), 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
    clear_fwd();
    dif.e_dstE = 4'h3; dif.W_dstE = 4'h5;
    @(posedge clk);
    #1;

    // Reset with random D inputs
    tick("reset");
    chk("reset.icode", 64'(dif.E_icode), 64'h1);
    chk("reset.dstE",  64'(dif.E_dstE),  64'hF);
    chk("reset.dstM",  64'(dif.E_dstM),  64'hF);
    chk("reset.srcA",  64'(dif.E_srcA),  64'hF);
    chk("reset.srcB",  64'(dif.E_srcB),  64'hF);
    chk("reset.valA",  dif.E_valA,       64'h0);
    rst = 1'b0;
    clear_fwd();
    decode(4'h6, 4'h3, 4'h3);
    tick("r3_after_reset");
    chk("r3_after_reset.valA", dif.E_valA, 64'h0);

    // Write R3 then read it back with no forwarding
    dif.W_dstE = 4'h3; dif.W_valE = 64'h10;
    decode(4'h1, 4'hF, 4'hF);
    tick("write_r3");
    clear_fwd();
    decode(4'h6, 4'h3, 4'h3);
    tick("read_r3");
    chk("read_r3.valA", dif.E_valA, 64'h10);
    chk("read_r3.valB", dif.E_valB, 64'h10);

    // Forwarding priority on srcA=2
    decode(4'h6, 4'h2, 4'h5);
    dif.e_dstE = 4'h2; dif.e_valE = 64'hAA;
    dif.M_dstE = 4'h2; dif.M_valE = 64'hBB;
    dif.W_dstM = 4'h2; dif.W_valM = 64'hCC;
    tick("fwd_e");
    chk("fwd_e.valA", dif.E_valA, 64'hAA);
    dif.e_dstE = 4'hF;
    tick("fwd_m");
    chk("fwd_m.valA", dif.E_valA, 64'hBB);
    dif.M_dstE = 4'hF;
    tick("fwd_w");
    chk("fwd_w.valA", dif.E_valA, 64'hCC);
    clear_fwd();

    // popq %rsp: W_valM wins the shared destination
    dif.W_dstE = 4'h4; dif.W_valE = 64'h108;
    dif.W_dstM = 4'h4; dif.W_valM = 64'h55;
    decode(4'h1, 4'hF, 4'hF);
    tick("popq_wb");
    clear_fwd();
    decode(4'h6, 4'h4, 4'hF);
    tick("popq_read");
    chk("popq_read.valA", dif.E_valA, 64'h55);

    // call decode with R4=0x200
    dif.W_dstE = 4'h4; dif.W_valE = 64'h200;
    tick("set_rsp");
    clear_fwd();
    decode(4'h8, 4'h0, 4'h0);
    dif.D_valP = 64'h20;
    tick("call");
    chk("call.valA", dif.E_valA, 64'h20);
    chk("call.valB", dif.E_valB, 64'h200);
    chk("call.srcB", 64'(dif.E_srcB), 64'h4);
    chk("call.dstE", 64'(dif.E_dstE), 64'h4);
    chk("call.dstM", 64'(dif.E_dstM), 64'hF);

    // Stall two cycles while D changes; the W write still lands
    saved_e = m_e;
    dif.E_stall = 1'b1;
    decode(4'h6, 4'h1, 4'h2); rand_data();
    dif.W_dstE = 4'h7; dif.W_valE = 64'h77;
    tick("stall1");
    decode(4'h2, 4'h5, 4'h6); rand_data();
    dif.W_dstE = 4'hF;
    tick("stall2");
    chk("stall.icode", 64'(dif.E_icode), 64'h8);
    chk("stall.valA",  dif.E_valA,       saved_e.vala);
    chk("stall.valB",  dif.E_valB,       64'h200);
    dif.E_stall = 1'b0;
    clear_fwd();
    decode(4'h6, 4'h7, 4'h7);
    tick("after_stall");
    chk("after_stall.valA", dif.E_valA, 64'h77);

    // Stall and bubble together -> bubble
    dif.E_stall = 1'b1; dif.E_bubble = 1'b1;
    tick("stall_bubble");
    chk("stall_bubble.icode", 64'(dif.E_icode), 64'h1);
    chk("stall_bubble.valA",  dif.E_valA,       64'h0);
    chk("stall_bubble.dstE",  64'(dif.E_dstE),  64'hF);
    dif.E_stall = 1'b0; dif.E_bubble = 1'b0;

    // Randomized run with colliding IDs
    for (int n = 0; n < 400; n++) begin
      rand_data();
      decode(4'($urandom_range(0, 11)), rand_id(), rand_id());
      dif.e_dstE = rand_id(); dif.M_dstE = rand_id(); dif.M_dstM = rand_id();
      dif.W_dstE = rand_id(); dif.W_dstM = rand_id();
      dif.E_stall  = ($urandom_range(0, 4) == 0);
      dif.E_bubble = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 39) == 0);
      tick("random");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
